// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared types and helpers for the up/down counter slice.
//   dir_t        : counting direction (DIR_DOWN / DIR_UP)
//   mode_t       : behaviour at the limits (MODE_WRAP / MODE_SAT)
//   presc_cnt_w  : width of the prescaler phase counter (never below 1 bit)
// -----------------------------------------------------------------------------
package counter_pkg;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;
  typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_t;

  function automatic int unsigned presc_cnt_w(input int unsigned presc);
    return (presc > 1) ? $clog2(presc) : 1;
  endfunction

endpackage

// File: rtl/counter_updown_mod_prescaler_tick.sv
// -----------------------------------------------------------------------------
// prescaler_tick
// Divides the enable into one tick every PRESC enabled cycles.
//   clk   in  system clock, rising edge
//   reset in  synchronous, active-high reset (phase -> 0)
//   en    in  advances the phase; tick can only occur while en is high
//   clr   in  synchronous phase clear (the counter's load strobe)
//   tick  out combinational: en & (phase == PRESC-1)
// With PRESC=1 the phase register never leaves 0, so tick reduces to en.
// -----------------------------------------------------------------------------
module prescaler_tick
  import counter_pkg::*;
#(
  parameter int unsigned PRESC = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned      CW   = presc_cnt_w(PRESC);
  localparam logic [CW-1:0]    LAST = CW'(PRESC - 1);

  logic [CW-1:0] r_presc_cnt;
  logic          w_last;

  assign w_last = (r_presc_cnt == LAST);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc_cnt <= '0;
    end else if (clr) begin
      r_presc_cnt <= '0;
    end else if (en) begin
      r_presc_cnt <= w_last ? '0 : r_presc_cnt + 1'b1;
    end
  end

  assign tick = en & w_last;

endmodule

// File: rtl/counter_updown_mod.sv
// -----------------------------------------------------------------------------
// counter_updown_mod
// Parametrised up/down counter with enable, synchronous load, programmable
// inclusive maximum, wrap/saturate limit handling, built-in prescaler and
// terminal-count output for ripple-enable cascading.
//   clk      in  system clock, rising edge
//   reset    in  synchronous, active-high reset (count -> RESET_VAL)
//   en       in  count enable (gates prescaler and counter)
//   up_dn    in  1 = up, 0 = down
//   load     in  synchronous parallel load of load_val (beats stepping)
//   load_val in  value taken by load, applied verbatim
//   max_val  in  inclusive upper limit, range is 0..max_val
//   sat_mode in  0 = wrap at limits, 1 = hold at limits
//   count    out registered count
//   tc       out combinational terminal count (drives next stage's en)
//   wrap_evt out registered one-cycle pulse after a wrap
// -----------------------------------------------------------------------------
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH     = 4,
  parameter int unsigned      PRESC     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap_evt
);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap_evt;

  logic             w_tick;
  dir_t             w_dir;
  mode_t            w_mode;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_out_of_range;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;

  prescaler_tick #(
    .PRESC (PRESC)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (load),
    .tick  (w_tick)
  );

  assign w_dir          = dir_t'(up_dn);
  assign w_mode         = mode_t'(sat_mode);
  assign w_at_max       = (r_count == max_val);
  assign w_at_zero      = (r_count == '0);
  assign w_out_of_range = (r_count > max_val);

  // Step logic. +1 is only taken below max_val and -1 only above 0, so the
  // native 2^WIDTH roll-over is never exercised.
  // NOTE: every always_comb output gets a default first; any path that would
  // otherwise leave it unassigned would infer a latch.
  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    if (w_tick) begin
      if (w_out_of_range) begin
        // Above the limit (after a load or a lowered max_val): pull back in.
        if (w_mode == MODE_SAT) begin
          w_count_nxt = max_val;
        end else begin
          w_count_nxt = '0;
          w_wrap_nxt  = 1'b1;
        end
      end else if (w_dir == DIR_UP) begin
        if (!w_at_max) begin
          w_count_nxt = r_count + 1'b1;
        end else if (w_mode == MODE_WRAP) begin
          w_count_nxt = '0;
          w_wrap_nxt  = 1'b1;
        end
      end else begin
        if (!w_at_zero) begin
          w_count_nxt = r_count - 1'b1;
        end else if (w_mode == MODE_WRAP) begin
          w_count_nxt = max_val;
          w_wrap_nxt  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= RESET_VAL;
      r_wrap_evt <= 1'b0;
    end else if (load) begin
      r_count    <= load_val;
      r_wrap_evt <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_wrap_evt <= w_wrap_nxt;
    end
  end

  // Terminal count is independent of sat_mode so a saturating stage still
  // enables its successor at the limit.
  assign tc       = w_tick & ~load & ((w_dir == DIR_UP) ? w_at_max : w_at_zero);
  assign count    = r_count;
  assign wrap_evt = r_wrap_evt;

endmodule
